// File: rtl/mesh_router.sv
// Five-port (N,S,E,W,L) mesh router tile: per-input FIFOs, XY routing on the
// FIFO heads, per-output round-robin arbitration and credit flow control.
module mesh_router #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int MESH_X  = 4,
  parameter int MESH_Y  = 4,
  parameter int X       = 0,
  parameter int Y       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0][DATA_W-1:0] data_i,
  input  logic [4:0]             valid_i,
  input  logic [4:0]             incr_i,
  output logic [4:0][DATA_W-1:0] data_o,
  output logic [4:0]             valid_o,
  output logic [4:0]             incr_o,
  output logic [2:0]             err_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Bit p set when port p has a neighbour (or is the local port).
  localparam logic [4:0] PORT_EN = {1'b1, X != 0, X != MESH_X - 1, Y != 0, Y != MESH_Y - 1};

  logic [DATA_W-1:0]     mem_q [5][DEPTH];
  logic [DATA_W-1:0]     mem_d [5][DEPTH];
  logic [4:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d, cred_q, cred_d;
  logic [4:0][2:0]       rr_q, rr_d;
  logic [4:0][DATA_W-1:0] data_q, data_d;
  logic [4:0]            valid_q, valid_d, incr_q, incr_d;
  logic [2:0]            err_q, err_d;

  logic [4:0][DATA_W-1:0] head;
  logic [4:0]             bad;
  logic [4:0][4:0]        req;   // req[out][in]
  logic [4:0][4:0]        gnt;   // gnt[out][in]
  logic [4:0]             cred_ovf;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // XY route decision for every non-empty FIFO head.
  always_comb begin
    logic [31:0] dx, dy;
    logic [2:0]  dir;
    head = '0;
    req  = '0;
    bad  = '0;
    dx   = '0;
    dy   = '0;
    dir  = 3'd4;
    for (int p = 0; p < 5; p++) begin
      head[p] = mem_q[p][rd_ptr_q[p]];
      dx = 32'(head[p][DATA_W-1 -: COORD_W]);
      dy = 32'(head[p][DATA_W-1-COORD_W -: COORD_W]);
      if      (dx > 32'(X)) dir = 3'd2;
      else if (dx < 32'(X)) dir = 3'd3;
      else if (dy > 32'(Y)) dir = 3'd0;
      else if (dy < 32'(Y)) dir = 3'd1;
      else                  dir = 3'd4;
      if (cnt_q[p] != '0 && PORT_EN[p]) begin
        if (dx >= 32'(MESH_X) || dy >= 32'(MESH_Y)) bad[p] = 1'b1;
        else                                        req[dir][p] = 1'b1;
      end
    end
  end

  // Round-robin grant per output, gated by downstream credit.
  always_comb begin
    logic [3:0] s;
    logic       found;
    logic       incr_ok;
    gnt      = '0;
    rr_d     = rr_q;
    cred_d   = cred_q;
    data_d   = '0;
    valid_d  = '0;
    cred_ovf = '0;
    s        = '0;
    found    = 1'b0;
    incr_ok  = 1'b0;
    for (int o = 0; o < 5; o++) begin
      found = 1'b0;
      if (PORT_EN[o] && cred_q[o] != '0) begin
        for (int k = 0; k < 5; k++) begin
          s = {1'b0, rr_q[o]} + 4'(k);
          if (s >= 4'd5) s = s - 4'd5;
          if (!found && req[o][s[2:0]]) begin
            found          = 1'b1;
            gnt[o][s[2:0]] = 1'b1;
            data_d[o]      = head[s[2:0]];
            rr_d[o]        = (s[2:0] == 3'd4) ? 3'd0 : s[2:0] + 3'd1;
          end
        end
      end
      valid_d[o] = found;
      incr_ok    = incr_i[o] & PORT_EN[o];
      if (found && !incr_ok) begin
        cred_d[o] = cred_q[o] - CNT_W'(1);
      end else if (!found && incr_ok) begin
        if (cred_q[o] == CNT_W'(DEPTH)) cred_ovf[o] = 1'b1;
        else                            cred_d[o]   = cred_q[o] + CNT_W'(1);
      end
    end
  end

  // Input FIFOs: push on valid_i, pop on grant or on an unroutable head.
  always_comb begin
    logic pop, wr, full;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    incr_d   = '0;
    err_d    = err_q;
    pop      = 1'b0;
    wr       = 1'b0;
    full     = 1'b0;
    for (int p = 0; p < 5; p++) begin
      pop = bad[p];
      for (int o = 0; o < 5; o++) pop = pop | gnt[o][p];
      wr   = valid_i[p] & PORT_EN[p];
      full = (cnt_q[p] == CNT_W'(DEPTH));
      if (wr && full) err_d[0] = 1'b1;
      if (wr && !full) begin
        mem_d[p][wr_ptr_q[p]] = data_i[p];
        wr_ptr_d[p]           = ptr_inc(wr_ptr_q[p]);
      end
      if (pop) rd_ptr_d[p] = ptr_inc(rd_ptr_q[p]);
      cnt_d[p]  = cnt_q[p] + CNT_W'(wr && !full) - CNT_W'(pop);
      incr_d[p] = pop;
      if (bad[p]) err_d[2] = 1'b1;
    end
    if (|cred_ovf) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      cred_q   <= {5{CNT_W'(DEPTH)}};
      rr_q     <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      incr_q   <= '0;
      err_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cred_q   <= cred_d;
      rr_q     <= rr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      incr_q   <= incr_d;
      err_q    <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign incr_o  = incr_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_mesh_router.sv
// Bench for mesh_router: directed latency/arbitration/credit/error cases, then
// randomized credit-respecting traffic checked by a scoreboard monitor.
module tb_mesh_router;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int N_CYC = 1500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0][DW-1:0] data_i, data_o, data_o2;
  logic [4:0] valid_i, incr_i, valid_o, incr_o, valid_o2, incr_o2;
  logic [2:0] err_o, err_o2;

  int n_checks = 0;
  int n_pass   = 0;
  bit sb_on    = 1'b0;
  logic [DW-1:0] exp_q [25][$];

  mesh_router #(.DATA_W(DW), .DEPTH(DEPTH), .COORD_W(CW), .MESH_X(4), .MESH_Y(4),
                .X(1), .Y(1)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .incr_i(incr_i),
    .data_o(data_o), .valid_o(valid_o), .incr_o(incr_o), .err_o(err_o));

  // Corner tile (0,0): W and S ports are absent.
  mesh_router #(.DATA_W(DW), .DEPTH(DEPTH), .COORD_W(CW), .MESH_X(4), .MESH_Y(4),
                .X(0), .Y(0)) dut_edge (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .incr_i(incr_i),
    .data_o(data_o2), .valid_o(valid_o2), .incr_o(incr_o2), .err_o(err_o2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Flit = {dest_x[2:0], dest_y[2:0], src[2:0], seq[6:0]}
  function automatic logic [DW-1:0] mk(input int dx, input int dy, input int src, input int seq);
    logic [2:0] a, b, c;
    logic [6:0] d;
    a = dx[2:0];
    b = dy[2:0];
    c = src[2:0];
    d = seq[6:0];
    return {a, b, c, d};
  endfunction

  // Expected output port for a tile sitting at (1,1).
  function automatic int ref_port(input int dx, input int dy);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 0;
    if (dy < 1) return 1;
    return 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = '0;
    incr_i  = '0;
    data_i  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  // Scoreboard monitor: every delivered flit must be the oldest outstanding one
  // from its source input towards that output.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_on) begin
        for (int o = 0; o < 5; o++) begin
          if (valid_o[o]) begin
            int src, key;
            src = int'(data_o[o][9:7]);
            key = src * 5 + o;
            if (src < 5 && exp_q[key].size() > 0) begin
              chk("sb_flit", data_o[o], exp_q[key].pop_front());
            end else begin
              n_checks++;
              $display("FAIL sb_unexpected: output %0d got flit %0h, required no flit", o, data_o[o]);
            end
          end
        end
        chk("edge_ports_idle", {valid_o2[3], valid_o2[1], incr_o2[3], incr_o2[1],
                                data_o2[3], data_o2[1]}, 0);
      end
    end
  end

  initial begin
    logic [DW-1:0] f;
    int cnt, other, idx, rem, n_sent, n_ret, n_bad, max_pend, dx, dy, csum;
    int arr[3];
    int up_cred[5];
    int pend[5];
    int seq[5];
    bit bad;

    idle();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_valid_o", valid_o, 0);
    chk("rst_incr_o", incr_o, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_data_o", data_o, 0);
    rst = 1'b1;

    // Local flit to (2,1): east output two cycles later, credit back to L.
    f = mk(2, 1, 4, 1);
    data_i[4] = f; valid_i[4] = 1'b1;
    tick(); idle();
    chk("lat_t1_valid", valid_o, 0);
    tick();
    chk("lat_t2_valid", valid_o, 5'b00100);
    chk("lat_t2_data", data_o[2], f);
    chk("lat_t2_incr", incr_o, 5'b10000);
    chk("edge_east_route", valid_o2, 5'b00100);
    tick();
    chk("lat_t3_valid", valid_o, 0);

    // N, S, W contend for L.
    do_reset();
    arr = '{0, 1, 3};
    for (int i = 0; i < 3; i++) begin
      data_i[arr[i]]  = mk(1, 1, arr[i], arr[i]);
      valid_i[arr[i]] = 1'b1;
    end
    tick(); idle(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("rr_order_valid", valid_o, 5'b10000);
      chk("rr_order_data", data_o[4], mk(1, 1, arr[i], arr[i]));
      tick();
    end
    chk("rr_gap", valid_o, 0);
    data_i[0] = mk(1, 1, 0, 9); valid_i[0] = 1'b1;
    data_i[4] = mk(1, 1, 4, 9); valid_i[4] = 1'b1;
    tick(); idle(); tick();
    chk("rr_next_winner", data_o[4], mk(1, 1, 4, 9));
    tick();
    chk("credit_block_l", valid_o, 0);
    incr_i[4] = 1'b1;
    tick(); idle();
    chk("credit_wait_l", valid_o, 0);
    tick();
    chk("credit_resume_valid", valid_o, 5'b10000);
    chk("credit_resume_data", data_o[4], mk(1, 1, 0, 9));

    // Five flits to E without any credit return.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      data_i[4] = mk(2, 1, 4, i); valid_i[4] = 1'b1;
      tick();
      cnt += int'(valid_o[2]);
    end
    idle();
    repeat (6) begin tick(); cnt += int'(valid_o[2]); end
    chk("no_credit_count", cnt, 4);
    incr_i[2] = 1'b1;
    tick(); idle();
    chk("held_5th", valid_o, 0);
    tick();
    chk("released_5th_valid", valid_o, 5'b00100);
    chk("released_5th_data", data_o[2], mk(2, 1, 4, 4));

    // Fill input N while output L has no credit.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      data_i[4] = mk(1, 1, 4, i); valid_i[4] = 1'b1;
      tick();
    end
    idle();
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      data_i[0] = mk(1, 1, 0, i); valid_i[0] = 1'b1;
      tick();
      if (i == 3) chk("fifo_no_ovf_yet", err_o, 0);
    end
    idle();
    chk("fifo_ovf", err_o, 3'b001);
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      incr_i[4] = (k < 4);
      tick();
      if (valid_o[4]) begin
        chk("fifo_order", data_o[4], mk(1, 1, 0, idx));
        idx++;
      end
    end
    idle();
    chk("fifo_drained_count", idx, 4);
    chk("fifo_err_sticky", err_o, 3'b001);

    // Unroutable destination, then a credit return at full credit.
    do_reset();
    data_i[4] = mk(7, 0, 4, 0); valid_i[4] = 1'b1;
    tick(); idle();
    chk("bad_t1_err", err_o, 0);
    tick();
    chk("bad_valid_o", valid_o, 0);
    chk("bad_incr_o", incr_o, 5'b10000);
    chk("bad_err", err_o, 3'b100);
    incr_i[0] = 1'b1;
    tick(); idle();
    chk("credit_ovf_err", err_o, 3'b110);
    repeat (3) tick();
    chk("err_sticky", err_o, 3'b110);

    // One-cycle reset in the middle of traffic.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 5; p++) begin
        data_i[p]  = mk(p % 4, (p + i) % 4, p, i);
        valid_i[p] = 1'b1;
      end
      tick();
    end
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_incr", incr_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_err", err_o, 0);
    chk("midrst_edge", {valid_o2, incr_o2}, 0);
    cnt = 0;
    other = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin data_i[4] = mk(2, 1, 4, 20 + i); valid_i[4] = 1'b1; end
      else idle();
      tick();
      for (int o = 0; o < 5; o++) begin
        if (valid_o[o]) begin
          if (o == 2 && data_o[2] == mk(2, 1, 4, 20 + cnt)) cnt++;
          else other++;
        end
      end
    end
    idle();
    chk("post_rst_credit", cnt, 4);
    chk("post_rst_no_stale", other, 0);

    // Absent ports of the corner tile ignore flits and credits.
    do_reset();
    data_i[3] = mk(0, 0, 3, 0); valid_i[3] = 1'b1; incr_i[3] = 1'b1;
    data_i[1] = mk(0, 0, 1, 0); valid_i[1] = 1'b1; incr_i[1] = 1'b1;
    tick(); idle(); tick();
    chk("edge_ignore_valid", valid_o2, 0);
    chk("edge_ignore_incr", incr_o2, 0);
    chk("edge_ignore_err", err_o2, 0);

    // Randomized traffic with credit-respecting upstream and downstream.
    do_reset();
    n_sent = 0; n_ret = 0; n_bad = 0; max_pend = 0;
    for (int p = 0; p < 5; p++) begin up_cred[p] = DEPTH; pend[p] = 0; seq[p] = 0; end
    sb_on = 1'b1;
    for (int c = 0; c < N_CYC + 200; c++) begin
      idle();
      if (c < N_CYC) begin
        for (int p = 0; p < 5; p++) begin
          if (up_cred[p] > 0 && $urandom_range(0, 3) != 0) begin
            bad = ($urandom_range(0, 15) == 0);
            dx  = bad ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            dy  = int'($urandom_range(0, 3));
            f   = mk(dx, dy, p, seq[p]);
            seq[p] = (seq[p] + 1) % 128;
            data_i[p]  = f;
            valid_i[p] = 1'b1;
            up_cred[p]--;
            n_sent++;
            if (bad) n_bad++;
            else exp_q[p * 5 + ref_port(dx, dy)].push_back(f);
          end
        end
      end
      for (int o = 0; o < 5; o++) begin
        if (pend[o] > 0 && $urandom_range(0, 2) != 0) begin
          incr_i[o] = 1'b1;
          pend[o]--;
        end
      end
      tick();
      for (int o = 0; o < 5; o++) begin
        if (valid_o[o]) begin
          pend[o]++;
          if (pend[o] > max_pend) max_pend = pend[o];
        end
      end
      for (int p = 0; p < 5; p++) begin
        if (incr_o[p]) begin up_cred[p]++; n_ret++; end
      end
    end
    idle();
    sb_on = 1'b0;
    rem = 0;
    for (int k = 0; k < 25; k++) rem += exp_q[k].size();
    csum = 0;
    for (int p = 0; p < 5; p++) csum += up_cred[p];
    chk("sb_all_delivered", rem, 0);
    chk("credit_returns", n_ret, n_sent);
    chk("upstream_credit_restored", csum, 5 * DEPTH);
    chk("downstream_credit_limit", (max_pend <= DEPTH), 1);
    chk("random_err", err_o, {(n_bad > 0), 2'b00});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
